seg7_button_monitor: RTL and testbench
======================================

# seg7_button_monitor

Parametrised, registered successor to the combinational button-to-segment mapper. It drives `N_DIGITS` active-low 7-segment digits from `N_BTN` active-low button lines. Idle segments glow at a programmable PWM duty, and pressed segments are fully lit. Each press is stretched so that single-frame joypad pulses stay visible. It sits between the joypad input path and the board's 7-segment pins.

## Interface
Parameters:
- `N_BTN`, 8, number of monitored buttons.
- `N_DIGITS`, 2, number of 7-segment digits driven.
- `PWM_BITS`, 4, width of the idle-glow PWM counter and of `idle_duty`.
- `PRESC_DIV`, 50000, clock cycles per hold tick; must be ≥ 1.
- `HOLD_TICKS`, 20, hold ticks a segment stays lit after release; 0 means no stretch.
- `SEG_MAP`, `seg7_pkg::DEFAULT_MAP`, per button: {digit index, segment index 0..6}.

Ports:
- `clk` in 1: system clock; the block uses one clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `buttons` in `N_BTN`: 0 means pressed; asynchronous to `clk`.
- `enable` in 1: 0 blanks all segments.
- `idle_duty` in `PWM_BITS`: glow duty for unpressed mapped segments.
- `odat` out `N_DIGITS`×7: active-low segment drive, bit 6..0 as in `seg7_pkg`.

## Operation
- **Input synchronisation.** `buttons` passes through a 2-FF synchroniser. All logic uses the synchronised `pressed[i] = ~btn_s[i]`.
- **Prescaler.** A counter runs 0..`PRESC_DIV`-1 and wraps. `tick` pulses for one cycle when the count equals `PRESC_DIV`-1.
- **Hold counter.** Each button has a counter `hold[i]` of width `clog2(HOLD_TICKS+1)`.
  - While `pressed[i]` is true, load `HOLD_TICKS`.
  - Otherwise, if `tick` and `hold[i]` ≠ 0, decrement.
  - A press takes priority over a simultaneous tick.
- **Active flag.** `active[i] = pressed[i] | (hold[i] ≠ 0)`.
- **PWM counter.** A free-running `PWM_BITS` counter wraps at 2^`PWM_BITS`. `glow = (pwm_cnt < idle_duty)`.
  - `idle_duty` = 0 means idle segments are off.
  - All-ones duty means idle segments are lit (2^B−1)/2^B of the time.
  - `idle_duty` is sampled combinationally every cycle. A change takes effect on the next compare, and there is no glitch hold-off.
- **Segment drive.** For a segment mapped by button i, the next value is `~(enable & (active[i] | glow))`, i.e. 0 = lit.
  - A segment with no button mapped to it is forced to 1 (off).
  - If two buttons map to the same segment, it is lit if either qualifies (OR).
  - A `SEG_MAP` entry with a digit index ≥ `N_DIGITS` is ignored.
- **Blanking.** `enable` = 0 blanks all segments regardless of activity. Counters keep running.

## Timing
- **Reset.** All of the following reset asynchronously:
  - synchroniser flops → 1 (released);
  - prescaler, PWM counter and all `hold[i]` → 0;
  - `odat` → all 1 (every segment off).
- **Registered output.** `odat` is a register. A press on `buttons` reaches `odat` 3 cycles after the first sampling edge: 2 synchroniser cycles plus 1 output register.
- **Release timing.** After release, the segment stays lit until `hold[i]` reaches 0. That is `HOLD_TICKS` ticks, so the on-time is between (`HOLD_TICKS`−1)·`PRESC_DIV` and `HOLD_TICKS`·`PRESC_DIV` cycles, plus 3 cycles of pipeline.
- **Re-press during hold.** Reloads `HOLD_TICKS` immediately, with no gap in lighting.
- **`HOLD_TICKS` = 0.** The segment follows `pressed` with 3-cycle latency.
- **`enable` and `idle_duty` changes.** Visible on `odat` 1 cycle later.
- **Reset mid-hold.** Clears the hold immediately. `odat` is all 1 while `reset_n` is low and for the first cycle after release.

## Structure
- **Package `seg7_pkg`:**
  - segment index constants `SEG_A`..`SEG_G`;
  - Game Boy button index constants (RIGHT=0, LEFT=1, UP=2, DOWN=3, A=4, B=5, SELECT=6, START=7);
  - typedef `seg_loc_t` {digit, seg};
  - `DEFAULT_MAP`. It places Down/Left/Select/Right/Up on digit 0 at segments 6/5/3/1/0, and B/Start/A on digit 1 at segments 6/3/1.
- **Sub-module `seg7_hold_stretch`:** one instance per button, containing the hold counter and the `active` output. The prescaler and PWM counter are shared at the top level.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-operation → `odat` = all 1 immediately. After release, the prescaler, PWM counter and hold counters are all 0.
- **Press latency.** With `PRESC_DIV`=4, `HOLD_TICKS`=3, `idle_duty`=0, drive `buttons[0]`=0 for 1 cycle:
  - `odat[0][1]` goes to 0 exactly 3 cycles after the sampling edge;
  - it returns to 1 after between 8 and 12 cycles of hold time, plus pipeline.
- **Re-press during hold.** Re-press `buttons[0]` after 2 ticks of hold → the segment stays 0 continuously, and the hold restarts at 3.
- **Glow duty.** With `PWM_BITS`=4, `idle_duty`=4, no press → each mapped segment is 0 for exactly 4 of every 16 cycles. Unmapped segments (digit 1, segments 5, 4, 2 and 0) stay 1 throughout.
- **Blanking.** Press Start with `enable`=0 → `odat` stays all 1. Raise `enable` → `odat[1][3]`=0 on the next cycle.
- **Prescaler/press collision.** With `HOLD_TICKS`=0 → `odat` tracks `buttons` with a fixed 3-cycle delay. Forcing a tick on the same cycle as a press → the hold count loads its full value rather than decrementing.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, map types and helpers for the button-to-7-segment monitor.
package seg7_pkg;

  // Segment bit positions inside one digit (bit 6..0 of a digit field)
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;
  localparam int unsigned N_SEGS = 7;

  // Game Boy joypad button indices
  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_SELECT = 6;
  localparam int unsigned BTN_START  = 7;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 3;

  // Where one button lands on the display
  typedef struct packed {
    logic [DIGIT_W-1:0] digit;
    logic [SEG_W-1:0]   seg;
  } seg_loc_t;

  function automatic seg_loc_t mk_loc(input int unsigned digit, input int unsigned seg);
    seg_loc_t loc;
    loc.digit = DIGIT_W'(digit);
    loc.seg   = SEG_W'(seg);
    return loc;
  endfunction

  // Counter width able to hold values 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Entry i belongs to button i (index 7 is the leftmost element)
  localparam seg_loc_t [7:0] DEFAULT_MAP = {
    mk_loc(1, SEG_D),  // START
    mk_loc(0, SEG_D),  // SELECT
    mk_loc(1, SEG_G),  // B
    mk_loc(1, SEG_B),  // A
    mk_loc(0, SEG_G),  // DOWN
    mk_loc(0, SEG_A),  // UP
    mk_loc(0, SEG_F),  // LEFT
    mk_loc(0, SEG_B)   // RIGHT
  };

endpackage

// File: rtl/seg7_hold_stretch.sv
// Per-button press stretcher: keeps a button "active" for HOLD_TICKS ticks after release.
module seg7_hold_stretch
  import seg7_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pressed,
  input  logic tick,
  output logic active_c
);

  localparam int unsigned HOLD_W = cnt_width(HOLD_TICKS + 1);

  logic [HOLD_W-1:0] hold;

  // Reload while pressed (wins over a tick), otherwise count down on ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
    end else if (pressed) begin
      hold <= HOLD_W'(HOLD_TICKS);
    end else if (tick && (hold != '0)) begin
      hold <= hold - HOLD_W'(1);
    end
  end

  assign active_c = pressed | (hold != '0);

endmodule

// File: rtl/seg7_button_monitor.sv
// Drives active-low 7-segment digits from active-low buttons with idle PWM glow and press stretch.
module seg7_button_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned N_BTN      = 8,
  parameter int unsigned N_DIGITS   = 2,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned PRESC_DIV  = 50000,
  parameter int unsigned HOLD_TICKS = 20,
  parameter seg_loc_t [N_BTN-1:0] SEG_MAP = DEFAULT_MAP
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_BTN-1:0]           buttons,
  input  logic                       enable,
  input  logic [PWM_BITS-1:0]        idle_duty,
  output logic [N_DIGITS-1:0][6:0]   odat
);

  localparam int unsigned PRESC_W = cnt_width(PRESC_DIV);

  logic [N_BTN-1:0]          btn_meta;
  logic [N_BTN-1:0]          btn_s;
  logic [N_BTN-1:0]          pressed;
  logic [N_BTN-1:0]          active;
  logic [PRESC_W-1:0]        presc;
  logic                      tick;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic                      glow;
  logic [N_DIGITS-1:0][6:0]  odat_next;

  // Two-stage synchroniser for the asynchronous button lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= '1;
      btn_s    <= '1;
    end else begin
      btn_meta <= buttons;
      btn_s    <= btn_meta;
    end
  end

  assign pressed = ~btn_s;

  // Hold-tick prescaler, wraps at PRESC_DIV-1
  assign tick = (presc == PRESC_W'(PRESC_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Free-running idle-glow PWM counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign glow = (pwm_cnt < idle_duty);

  for (genvar i = 0; i < N_BTN; i++) begin : g_hold
    seg7_hold_stretch #(
      .HOLD_TICKS (HOLD_TICKS)
    ) u_hold (
      .clk      (clk),
      .reset_n  (reset_n),
      .pressed  (pressed[i]),
      .tick     (tick),
      .active_c (active[i])
    );
  end

  // Gather every button mapped onto each segment; unmapped segments stay dark
  always_comb begin
    logic hit;
    logic lit;
    odat_next = '1;
    hit       = 1'b0;
    lit       = 1'b0;
    for (int unsigned d = 0; d < N_DIGITS; d++) begin
      for (int unsigned s = 0; s < N_SEGS; s++) begin
        hit = 1'b0;
        lit = 1'b0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
          if ((32'(SEG_MAP[i].digit) == d) && (32'(SEG_MAP[i].seg) == s)) begin
            hit = 1'b1;
            lit = lit | active[i];
          end
        end
        if (hit) begin
          odat_next[d][s] = ~(enable & (lit | glow));
        end
      end
    end
  end

  // Registered segment drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      odat <= '1;
    end else begin
      odat <= odat_next;
    end
  end

endmodule

// File: tb/tb_seg7_button_monitor.sv
// Directed bench for seg7_button_monitor (PRESC_DIV=4, HOLD_TICKS=3, plus a HOLD_TICKS=0 copy).
module tb_seg7_button_monitor;
  import seg7_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [7:0]       buttons = '1;
  logic [3:0]       idle_duty = '0;
  logic [1:0][6:0]  odat;
  logic [1:0][6:0]  odat_nh;

  int total = 0;
  int bad   = 0;

  // Lit-segment masks of the default map: digit 1 uses G/D/B, digit 0 uses G/F/D/B/A
  logic [1:0][6:0] mapped_mask = {7'b1001010, 7'b1101011};

  always #5 clk = ~clk;

  seg7_button_monitor #(
    .N_BTN(8), .N_DIGITS(2), .PWM_BITS(4), .PRESC_DIV(4), .HOLD_TICKS(3), .SEG_MAP(DEFAULT_MAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .enable(enable),
    .idle_duty(idle_duty), .odat(odat)
  );

  seg7_button_monitor #(
    .N_BTN(8), .N_DIGITS(2), .PWM_BITS(4), .PRESC_DIV(4), .HOLD_TICKS(0), .SEG_MAP(DEFAULT_MAP)
  ) dut_nh (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .enable(enable),
    .idle_duty(idle_duty), .odat(odat_nh)
  );

  // Reset both copies; returns on the falling edge where reset_n is released (cycle 0)
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // From cycle 0, hold buttons[0] low during [a0,a1) and [b0,b1); report first lit and first dark cycle
  task automatic pulse_run(input int a0, input int a1, input int b0, input int b1,
                           output int first_low, output int first_high);
    logic v;
    first_low  = -1;
    first_high = -1;
    for (int j = 0; j < 48; j++) begin
      if (j > 0) @(negedge clk);
      buttons[0] = ((j >= a0 && j < a1) || (j >= b0 && j < b1)) ? 1'b0 : 1'b1;
      v = odat[0][1];
      if (first_low < 0) begin
        if (v == 1'b0) first_low = j;
      end else if (first_high < 0 && v == 1'b1) begin
        first_high = j;
      end
    end
    buttons[0] = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    idle_duty = '0;
    buttons = '1;
    do_reset();
    buttons[0] = 1'b0;
    @(negedge clk);
    buttons[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (odat[0][1] !== 1'b0) begin
      bad++; $display("FAIL reset_pre_lit: got %b want 0", odat[0][1]);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (odat !== '1) begin
      bad++; $display("FAIL reset_async: got %h want 3fff", odat);
    end
    idle_duty = 4'd1;
    @(negedge clk);
    reset_n = 1'b1;
    total++;
    if (odat !== '1) begin
      bad++; $display("FAIL reset_first_cycle: got %h want 3fff", odat);
    end
    // pwm restarts at 0, so duty 1 glows on exactly the first cycle
    @(negedge clk);
    total++;
    if (odat[0] !== ~mapped_mask[0] || odat[1] !== ~mapped_mask[1]) begin
      bad++; $display("FAIL reset_pwm_zero: got %h want %h", odat, ~mapped_mask);
    end
    // hold was cleared by reset, so button 0's segment must be dark now
    @(negedge clk);
    total++;
    if (odat !== '1) begin
      bad++; $display("FAIL reset_hold_clear: got %h want 3fff", odat);
    end
    idle_duty = '0;
  endtask

  // Press at cycle 0 -> lit at cycle 3; hold 3 loads at edge 3, ticks at edges 4,8,12 -> dark at 13
  task automatic test_press_latency();
    int lo, hi;
    do_reset();
    pulse_run(0, 1, -1, -1, lo, hi);
    total++;
    if (lo !== 3) begin
      bad++; $display("FAIL press_latency: got %0d want 3", lo);
    end
    total++;
    if (hi !== 13) begin
      bad++; $display("FAIL press_release: got %0d want 13", hi);
    end
  endtask

  // Re-press sampled at edge 9 reloads hold at edge 11; ticks 12,16,20 -> dark at 21 with no gap
  task automatic test_repress();
    int lo, hi;
    do_reset();
    pulse_run(0, 1, 8, 9, lo, hi);
    total++;
    if (lo !== 3) begin
      bad++; $display("FAIL repress_lit: got %0d want 3", lo);
    end
    total++;
    if (hi !== 21) begin
      bad++; $display("FAIL repress_continuous: got %0d want 21", hi);
    end
  endtask

  // Release at cycle 10 makes the last load coincide with the tick at edge 12: hold must be 3, dark at 25
  task automatic test_collision();
    int lo, hi;
    do_reset();
    pulse_run(0, 10, -1, -1, lo, hi);
    total++;
    if (lo !== 3) begin
      bad++; $display("FAIL collision_lit: got %0d want 3", lo);
    end
    total++;
    if (hi !== 25) begin
      bad++; $display("FAIL collision_priority: got %0d want 25", hi);
    end
  endtask

  // HOLD_TICKS=0 copy follows buttons[0] three cycles later
  task automatic test_no_hold();
    logic [23:0] pat;
    logic        exp;
    pat = 24'b0110_0010_1110_0100_1001_1011;
    do_reset();
    for (int j = 0; j < 24; j++) begin
      if (j > 0) @(negedge clk);
      buttons[0] = pat[j];
      exp = (j < 3) ? 1'b1 : pat[j-3];
      total++;
      if (odat_nh[0][1] !== exp) begin
        bad++; $display("FAIL no_hold_track[%0d]: got %b want %b", j, odat_nh[0][1], exp);
      end
    end
    buttons = '1;
  endtask

  task automatic test_glow();
    int lows [2][7];
    do_reset();
    idle_duty = 4'd4;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 7; s++) lows[d][s] = 0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 7; s++)
          if (odat[d][s] == 1'b0) lows[d][s]++;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 7; s++) begin
        total++;
        if (lows[d][s] !== (mapped_mask[d][s] ? 4 : 0)) begin
          bad++;
          $display("FAIL glow_duty[%0d][%0d]: got %0d lit cycles want %0d",
                   d, s, lows[d][s], mapped_mask[d][s] ? 4 : 0);
        end
      end
    end
    idle_duty = '0;
  endtask

  task automatic test_blank();
    do_reset();
    enable = 1'b0;
    buttons[7] = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (odat !== '1) begin
      bad++; $display("FAIL blank_start: got %h want 3fff", odat);
    end
    enable = 1'b1;
    @(negedge clk);
    total++;
    if (odat[1] !== 7'b1110111 || odat[0] !== 7'h7f) begin
      bad++; $display("FAIL blank_release: got %h want %h", odat, {7'b1110111, 7'h7f});
    end
    enable = 1'b0;
    @(negedge clk);
    total++;
    if (odat !== '1) begin
      bad++; $display("FAIL blank_reassert: got %h want 3fff", odat);
    end
    buttons = '1;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_repress();
    test_collision();
    test_no_hold();
    test_glow();
    test_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
